// File: rtl/msb_first_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready load and per-bit frame flags.
// Define SERIALIZER_BACK2BACK_EN to allow a new word to be accepted during the frame_end cycle.
module msb_first_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             x_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             x_d, bv_d, fs_d, fe_d;
   logic             accept;

   // cnt_q is the index of the bit currently on x_out; 0 marks the LSB cycle.
`ifdef SERIALIZER_BACK2BACK_EN
   assign load_ready = (state_q == IDLE) || (cnt_q == '0);
`else
   assign load_ready = (state_q == IDLE);
`endif

   assign accept = load_valid & load_ready;
   assign busy   = bit_valid;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      x_d     = 1'b0;
      bv_d    = 1'b0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;

      if (accept) begin
         state_d = SHIFT;
         cnt_d   = CNT_TOP;
         x_d     = data_in[WIDTH-1];
         shreg_d = data_in << 1;
         bv_d    = 1'b1;
         fs_d    = 1'b1;
      end else if (state_q == SHIFT) begin
         if (cnt_q == '0) begin
            state_d = IDLE;
         end else begin
            cnt_d   = cnt_q - CW'(1);
            x_d     = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
            bv_d    = 1'b1;
            fe_d    = (cnt_q == CW'(1));
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         x_out       <= 1'b0;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         x_out       <= x_d;
         bit_valid   <= bv_d;
         frame_start <= fs_d;
         frame_end   <= fe_d;
      end
   end

endmodule

// File: tb/tb_msb_first_serializer.sv
// Self-checking bench for msb_first_serializer: WIDTH=8 and WIDTH=2 instances driven side by side
// against a bit-position reference model plus a word-reassembly scoreboard.
module tb_msb_first_serializer;

`ifdef SERIALIZER_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8, v8, rdy8, x8, bv8, fs8, fe8, busy8;
   logic [7:0] d8;
   logic       rst2, v2, rdy2, x2, bv2, fs2, fe2, busy2;
   logic [1:0] d2;

   msb_first_serializer #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .data_in(d8), .load_valid(v8), .load_ready(rdy8),
      .x_out(x8), .bit_valid(bv8), .frame_start(fs8), .frame_end(fe8), .busy(busy8)
   );

   msb_first_serializer #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst2), .data_in(d2), .load_valid(v2), .load_ready(rdy2),
      .x_out(x2), .bit_valid(bv2), .frame_start(fs2), .frame_end(fe2), .busy(busy2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pos is the index (0 = MSB) of the bit expected on x_out, -1 when idle.
   int         pos8 = -1;
   int         pos2 = -1;
   logic [7:0] word8 = '0;
   logic [1:0] word2 = '0;
   logic [7:0] exp_q[$];
   logic [7:0] asm8 = '0;
   int         cnt_bv8 = 0, cnt_fs8 = 0, cnt_fe8 = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_ready(input int w, input int pos);
      return (pos < 0) || (B2B && pos == w - 1);
   endfunction

   task automatic check_outputs();
      logic ex8, ex2;
      ex8 = (pos8 >= 0) ? word8[7 - pos8] : 1'b0;
      ex2 = (pos2 >= 0) ? word2[1 - pos2] : 1'b0;
      check("w8_x",     x8,    ex8);
      check("w8_valid", bv8,   pos8 >= 0);
      check("w8_busy",  busy8, pos8 >= 0);
      check("w8_start", fs8,   pos8 == 0);
      check("w8_end",   fe8,   pos8 == 7);
      check("w8_ready", rdy8,  model_ready(8, pos8));
      check("w2_x",     x2,    ex2);
      check("w2_valid", bv2,   pos2 >= 0);
      check("w2_start", fs2,   pos2 == 0);
      check("w2_end",   fe2,   pos2 == 1);
      check("w2_ready", rdy2,  model_ready(2, pos2));

      // Reassemble each WIDTH=8 frame from the serial stream and compare to the accepted word.
      if (bv8) begin
         cnt_bv8++;
         if (fs8) begin
            cnt_fs8++;
            asm8 = '0;
         end
         asm8 = {asm8[6:0], x8};
         if (fe8) begin
            cnt_fe8++;
            check("sb_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("sb_word", asm8, exp_q.pop_front());
         end
      end
   endtask

   task automatic step(input logic r_8, input logic v_8, input logic [7:0] dd8,
                       input logic r_2, input logic v_2, input logic [1:0] dd2);
      logic acc8, acc2;
      rst8 = r_8; v8 = v_8; d8 = dd8;
      rst2 = r_2; v2 = v_2; d2 = dd2;
      acc8 = !r_8 && v_8 && model_ready(8, pos8);
      acc2 = !r_2 && v_2 && model_ready(2, pos2);
      @(posedge clk);
      if (r_8) begin
         pos8 = -1;
         exp_q.delete();
      end else if (acc8) begin
         word8 = dd8;
         pos8  = 0;
         exp_q.push_back(dd8);
      end else if (pos8 >= 0) begin
         pos8 = (pos8 == 7) ? -1 : pos8 + 1;
      end
      if (r_2) begin
         pos2 = -1;
      end else if (acc2) begin
         word2 = dd2;
         pos2  = 0;
      end else if (pos2 >= 0) begin
         pos2 = (pos2 == 1) ? -1 : pos2 + 1;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle8(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 2'b00);
   endtask

   task automatic clear_counts();
      cnt_bv8 = 0; cnt_fs8 = 0; cnt_fe8 = 0;
   endtask

   initial begin
      // Reset with load_valid high: nothing may be accepted.
      step(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 2'b11);
      step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 2'b10);
      idle8(1);

      // Single word 0xA4.
      clear_counts();
      step(1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 2'b00);
      idle8(10);
      check("a4_bv_cnt", cnt_bv8, 8);
      check("a4_fs_cnt", cnt_fs8, 1);
      check("a4_fe_cnt", cnt_fe8, 1);

      // load_valid held: 0xFF then 0x00 (gap or no gap depending on build).
      clear_counts();
      step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'b00);
      idle8(8);
      check("ff00_bv_cnt", cnt_bv8, 16);
      check("ff00_fe_cnt", cnt_fe8, 2);

      // Reset pulsed while bit 4 of 0x5A is on x_out, then 0x01.
      clear_counts();
      step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 2'b00);
      idle8(4);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
      check("abort_fe_cnt", cnt_fe8, 0);
      step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 2'b00);
      idle8(9);
      check("w01_fe_cnt", cnt_fe8, 1);

      // WIDTH=2: 0b10 then 0b11.
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b11);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);

      // Random traffic: data_in toggles every cycle, load_valid mostly high, rare resets.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 2'($urandom));
      end
      idle8(10);
      check("sb_left", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
